calc_sequencer: RTL and testbench

- Operation sequencer for the calculator datapath.
- Captures operand A and operand B from the switch-entry value on debounced enter pulses, then latches the arithmetic op.
- Issues a one-cycle start to the arithmetic unit and waits for done/error, with a timeout.
- Drives the display-source select and the state LEDs.
- Sits between the push-button pulse generators / input value setup and the calculate unit and display mux.

---
 rtl/calc_sequencer_if.sv | 46 ++++
 rtl/calc_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_sequencer_if.sv
// ============================================================================
// Module      : calc_sequencer_if
// Description : Handshake/data bundle between the calculator operation
//               sequencer (master) and its surroundings: push-button pulse
//               generators, value entry, arithmetic unit and display mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface calc_sequencer_if #(
  parameter int WIDTH = 40
);
  logic             enter_pulse;
  logic             clear_pulse;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] in_val;
  logic             alu_done;
  logic             alu_err;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       alu_op;
  logic             alu_start;
  logic [1:0]       disp_sel;
  logic [3:0]       state_led;
  logic             err_flag;
  logic             busy;

  // Sequencer side
  modport master (
    input  enter_pulse, clear_pulse, op_sel, in_val,
    input  alu_done, alu_err, alu_result,
    output op_a, op_b, alu_op, alu_start,
    output disp_sel, state_led, err_flag, busy
  );

  // Environment side (buttons, entry, arithmetic unit, display)
  modport slave (
    output enter_pulse, clear_pulse, op_sel, in_val,
    output alu_done, alu_err, alu_result,
    input  op_a, op_b, alu_op, alu_start,
    input  disp_sel, state_led, err_flag, busy
  );
endinterface

`default_nettype wire

// File: rtl/calc_sequencer.sv
// ============================================================================
// Module      : calc_sequencer
// Description : Operation sequencer for the calculator datapath. Captures
//               operand A, operand B and the op on enter pulses, fires a
//               one-cycle ALU start, waits for done/error with a timeout and
//               drives display select / state LEDs. All outputs registered.
//               Optional macro CALC_SEQ_CHAIN_EN: enter in SHOW reuses the
//               result as operand A and jumps to GET_B (LEDs show 0011).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_sequencer #(
  parameter int WIDTH       = 40,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 11
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  calc_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_GET_A = 3'd0,
    S_GET_B = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_SHOW  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_op_a, w_op_a_nxt;
  logic [WIDTH-1:0] r_op_b, w_op_b_nxt;
  logic [WIDTH-1:0] r_res, w_res_nxt;
  logic [1:0]       r_alu_op, w_alu_op_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_chained, w_chained_nxt;
  logic             r_alu_start, w_alu_start;
  logic [1:0]       r_disp_sel, w_disp_sel;
  logic [3:0]       r_state_led, w_state_led;
  logic             r_err_flag, w_err_flag;
  logic             r_busy, w_busy;

  // State register plus all datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_GET_A;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_res       <= '0;
      r_alu_op    <= '0;
      r_cnt       <= '0;
      r_chained   <= 1'b0;
      r_alu_start <= 1'b0;
      r_disp_sel  <= 2'b00;
      r_state_led <= 4'b0001;
      r_err_flag  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_op_a      <= w_op_a_nxt;
      r_op_b      <= w_op_b_nxt;
      r_res       <= w_res_nxt;
      r_alu_op    <= w_alu_op_nxt;
      r_cnt       <= w_cnt_nxt;
      r_chained   <= w_chained_nxt;
      r_alu_start <= w_alu_start;
      r_disp_sel  <= w_disp_sel;
      r_state_led <= w_state_led;
      r_err_flag  <= w_err_flag;
      r_busy      <= w_busy;
    end
  end

  // Next-state/datapath decisions; outputs decoded from the next state so
  // they appear registered in the same cycle the state changes
  always_comb begin
    w_state_nxt   = r_state;
    w_op_a_nxt    = r_op_a;
    w_op_b_nxt    = r_op_b;
    w_res_nxt     = r_res;
    w_alu_op_nxt  = r_alu_op;
    w_cnt_nxt     = r_cnt;
    w_chained_nxt = r_chained;

    if (bus.clear_pulse) begin
      // Clear outranks enter and alu_done in every state
      w_state_nxt   = S_GET_A;
      w_op_a_nxt    = '0;
      w_op_b_nxt    = '0;
      w_res_nxt     = '0;
      w_alu_op_nxt  = '0;
      w_cnt_nxt     = '0;
      w_chained_nxt = 1'b0;
    end else begin
      case (r_state)
        S_GET_A: begin
          if (bus.enter_pulse) begin
            w_op_a_nxt    = bus.in_val;
            w_chained_nxt = 1'b0;
            w_state_nxt   = S_GET_B;
          end
        end
        S_GET_B: begin
          if (bus.enter_pulse) begin
            w_op_b_nxt    = bus.in_val;
            w_alu_op_nxt  = bus.op_sel;
            w_chained_nxt = 1'b0;
            w_state_nxt   = S_START;
          end
        end
        S_START: begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          // done beats a timeout landing on the same cycle
          if (bus.alu_done) begin
            if (bus.alu_err) begin
              w_state_nxt = S_ERROR;
            end else begin
              w_res_nxt   = bus.alu_result;
              w_state_nxt = S_SHOW;
            end
          end else if (r_cnt == c_cnt_last) begin
            w_state_nxt = S_ERROR;
          end else if (r_cnt != c_cnt_max) begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end
        S_SHOW: begin
          if (bus.enter_pulse) begin
`ifdef CALC_SEQ_CHAIN_EN
            w_op_a_nxt    = r_res;
            w_chained_nxt = 1'b1;
            w_state_nxt   = S_GET_B;
`else
            w_op_a_nxt    = '0;
            w_op_b_nxt    = '0;
            w_state_nxt   = S_GET_A;
`endif
          end
        end
        S_ERROR: begin
          if (bus.enter_pulse) begin
            w_op_a_nxt  = '0;
            w_op_b_nxt  = '0;
            w_res_nxt   = '0;
            w_state_nxt = S_GET_A;
          end
        end
        default: begin
          w_state_nxt = S_GET_A;
        end
      endcase
    end

    w_alu_start = (w_state_nxt == S_START);
    w_disp_sel  = 2'b00;
    w_state_led = 4'b0001;
    w_err_flag  = 1'b0;
    w_busy      = 1'b0;
    case (w_state_nxt)
      S_GET_A: begin
        w_disp_sel  = 2'b00;
        w_state_led = 4'b0001;
      end
      S_GET_B: begin
        w_disp_sel  = 2'b01;
        w_state_led = w_chained_nxt ? 4'b0011 : 4'b0010;
      end
      S_START, S_WAIT: begin
        w_disp_sel  = 2'b11;
        w_state_led = 4'b0100;
        w_busy      = 1'b1;
      end
      S_SHOW: begin
        w_disp_sel  = 2'b11;
        w_state_led = 4'b1000;
      end
      S_ERROR: begin
        w_disp_sel  = 2'b10;
        w_state_led = 4'b1111;
        w_err_flag  = 1'b1;
      end
      default: begin
        w_disp_sel  = 2'b00;
        w_state_led = 4'b0001;
      end
    endcase
  end

  assign bus.op_a      = r_op_a;
  assign bus.op_b      = r_op_b;
  assign bus.alu_op    = r_alu_op;
  assign bus.alu_start = r_alu_start;
  assign bus.disp_sel  = r_disp_sel;
  assign bus.state_led = r_state_led;
  assign bus.err_flag  = r_err_flag;
  assign bus.busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_calc_sequencer.sv
// ============================================================================
// Module      : tb_calc_sequencer
// Description : Self-checking bench for calc_sequencer (TIMEOUT_CYC=8).
//               Directed steps plus randomized operations; the bench plays
//               the arithmetic unit with plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_sequencer;
  localparam int W = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  calc_sequencer_if #(.WIDTH(W)) bus ();

  calc_sequencer #(.WIDTH(W), .TIMEOUT_CYC(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ui(input string tag, input logic [1:0] sel, input logic [3:0] led,
                        input logic bsy, input logic err);
    chk({tag, ".disp_sel"}, 64'(bus.disp_sel), 64'(sel));
    chk({tag, ".state_led"}, 64'(bus.state_led), 64'(led));
    chk({tag, ".busy"}, 64'(bus.busy), 64'(bsy));
    chk({tag, ".err_flag"}, 64'(bus.err_flag), 64'(err));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter(input logic [W-1:0] v, input logic [1:0] op);
    bus.in_val = v;
    bus.op_sel = op;
    bus.enter_pulse = 1'b1;
    tick();
    bus.enter_pulse = 1'b0;
  endtask

  task automatic clear();
    bus.clear_pulse = 1'b1;
    tick();
    bus.clear_pulse = 1'b0;
  endtask

  task automatic done(input logic [W-1:0] r, input logic e);
    bus.alu_result = r;
    bus.alu_err = e;
    bus.alu_done = 1'b1;
    tick();
    bus.alu_done = 1'b0;
    bus.alu_err = 1'b0;
  endtask

  // Behavioural arithmetic unit
  function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a * b;
      default: return (b == 0) ? '0 : a / b;
    endcase
  endfunction

  initial begin
    logic [63:0]  rnd;
    logic [W-1:0] a, b, r;
    logic [1:0]   op;
    logic         e;
    int           d;

    bus.enter_pulse = 1'b0;
    bus.clear_pulse = 1'b0;
    bus.op_sel      = 2'b00;
    bus.in_val      = '0;
    bus.alu_done    = 1'b0;
    bus.alu_err     = 1'b0;
    bus.alu_result  = '0;

    // Reset state
    tick();
    tick();
    chk("rst.op_a", 64'(bus.op_a), 64'd0);
    chk("rst.op_b", 64'(bus.op_b), 64'd0);
    chk("rst.alu_op", 64'(bus.alu_op), 64'd0);
    chk("rst.alu_start", 64'(bus.alu_start), 64'd0);
    chk_ui("rst", 2'b00, 4'b0001, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic add 25 + 17
    enter(40'd25, 2'b11);
    chk_ui("add.getb", 2'b01, 4'b0010, 1'b0, 1'b0);
    chk("add.start_early", 64'(bus.alu_start), 64'd0);
    enter(40'd17, 2'b00);
    chk("add.alu_start", 64'(bus.alu_start), 64'd1);
    chk("add.op_a", 64'(bus.op_a), 64'd25);
    chk("add.op_b", 64'(bus.op_b), 64'd17);
    chk("add.alu_op", 64'(bus.alu_op), 64'd0);
    chk_ui("add.start", 2'b11, 4'b0100, 1'b1, 1'b0);
    tick();
    chk("add.start_one_cycle", 64'(bus.alu_start), 64'd0);
    chk_ui("add.wait", 2'b11, 4'b0100, 1'b1, 1'b0);
    done(40'd42, 1'b0);
    chk_ui("add.show", 2'b11, 4'b1000, 1'b0, 1'b0);
    chk("add.show.op_a", 64'(bus.op_a), 64'd25);
    enter(40'd0, 2'b00);
`ifdef CALC_SEQ_CHAIN_EN
    chk("chain.op_a", 64'(bus.op_a), 64'd42);
    chk_ui("chain.getb", 2'b01, 4'b0011, 1'b0, 1'b0);
    enter(40'd2, 2'b10);
    chk("chain.alu_start", 64'(bus.alu_start), 64'd1);
    chk("chain.op_a2", 64'(bus.op_a), 64'd42);
    chk("chain.op_b", 64'(bus.op_b), 64'd2);
    chk("chain.alu_op", 64'(bus.alu_op), 64'd2);
    tick();
    done(40'd84, 1'b0);
    clear();
`else
    chk("nochain.op_a", 64'(bus.op_a), 64'd0);
    chk("nochain.op_b", 64'(bus.op_b), 64'd0);
    chk_ui("nochain.geta", 2'b00, 4'b0001, 1'b0, 1'b0);
`endif

    // Divide by zero reported by the ALU
    enter(40'd99, 2'b00);
    enter(40'd0, 2'b11);
    tick();
    done(40'd0, 1'b1);
    chk_ui("err", 2'b10, 4'b1111, 1'b0, 1'b1);
    enter(40'd5, 2'b00);
    chk_ui("err.exit", 2'b00, 4'b0001, 1'b0, 1'b0);
    chk("err.exit.op_a", 64'(bus.op_a), 64'd0);

    // Timeout: ERROR exactly 8 cycles after entering WAIT
    enter(40'd1, 2'b00);
    enter(40'd2, 2'b00);
    tick();
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("tmo.busy%0d", i), 64'(bus.busy), 64'(i < 8));
      chk($sformatf("tmo.err%0d", i), 64'(bus.err_flag), 64'(i == 8));
    end
    chk("tmo.led", 64'(bus.state_led), 64'b1111);
    clear();
    chk_ui("tmo.clear", 2'b00, 4'b0001, 1'b0, 1'b0);

    // Done on the 8th WAIT cycle beats the timeout
    enter(40'd3, 2'b00);
    enter(40'd4, 2'b00);
    tick();
    for (int i = 1; i <= 7; i++) tick();
    chk("tmo2.still_wait", 64'(bus.busy), 64'd1);
    done(40'd7, 1'b0);
    chk_ui("tmo2.show", 2'b11, 4'b1000, 1'b0, 1'b0);
    clear();

    // Clear and enter together in GET_B
    enter(40'd5, 2'b00);
    bus.in_val = 40'd6;
    bus.clear_pulse = 1'b1;
    bus.enter_pulse = 1'b1;
    tick();
    bus.clear_pulse = 1'b0;
    bus.enter_pulse = 1'b0;
    chk("prio.op_b", 64'(bus.op_b), 64'd0);
    chk("prio.op_a", 64'(bus.op_a), 64'd0);
    chk_ui("prio", 2'b00, 4'b0001, 1'b0, 1'b0);

    // Enter during WAIT is ignored
    enter(40'd7, 2'b00);
    enter(40'd9, 2'b01);
    tick();
    enter(40'd123, 2'b10);
    enter(40'd124, 2'b11);
    chk("ign.op_b", 64'(bus.op_b), 64'd9);
    chk("ign.alu_op", 64'(bus.alu_op), 64'd1);
    chk_ui("ign.wait", 2'b11, 4'b0100, 1'b1, 1'b0);
    clear();
    chk("clr.op_a", 64'(bus.op_a), 64'd0);
    chk("clr.alu_op", 64'(bus.alu_op), 64'd0);

    // Reset asserted mid-WAIT, late done afterwards
    enter(40'd11, 2'b01);
    enter(40'd22, 2'b10);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst.op_a", 64'(bus.op_a), 64'd0);
    chk("arst.op_b", 64'(bus.op_b), 64'd0);
    chk("arst.alu_op", 64'(bus.alu_op), 64'd0);
    chk_ui("arst", 2'b00, 4'b0001, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    done(40'd99, 1'b0);
    chk_ui("arst.late_done", 2'b00, 4'b0001, 1'b0, 1'b0);

    // Randomized operations
    for (int k = 0; k < 10; k++) begin
      rnd = {$urandom, $urandom};
      a = rnd[W-1:0];
      rnd = {$urandom, $urandom};
      b = rnd[W-1:0];
      op = 2'($urandom_range(0, 3));
      if (k % 3 == 0) begin
        op = 2'b11;
        b = '0;
      end
      e = (op == 2'b11) && (b == 0);
      r = alu_model(a, b, op);
      enter(a, 2'($urandom_range(0, 3)));
      chk("rnd.getb", 64'(bus.state_led), 64'b0010);
      enter(b, op);
      chk("rnd.start", 64'(bus.alu_start), 64'd1);
      chk("rnd.op_a", 64'(bus.op_a), 64'(a));
      chk("rnd.op_b", 64'(bus.op_b), 64'(b));
      chk("rnd.alu_op", 64'(bus.alu_op), 64'(op));
      tick();
      d = $urandom_range(0, 5);
      for (int j = 0; j < d; j++) tick();
      chk("rnd.busy", 64'(bus.busy), 64'd1);
      done(r, e);
      if (e) chk_ui("rnd.err", 2'b10, 4'b1111, 1'b0, 1'b1);
      else   chk_ui("rnd.show", 2'b11, 4'b1000, 1'b0, 1'b0);
      enter(40'd0, 2'b00);
`ifdef CALC_SEQ_CHAIN_EN
      if (!e) begin
        chk("rnd.chain.op_a", 64'(bus.op_a), 64'(r));
        chk("rnd.chain.led", 64'(bus.state_led), 64'b0011);
        clear();
      end else begin
        chk("rnd.exit.op_a", 64'(bus.op_a), 64'd0);
      end
`else
      chk("rnd.exit.op_a", 64'(bus.op_a), 64'd0);
      chk("rnd.exit.led", 64'(bus.state_led), 64'b0001);
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

`default_nettype wire
